output_event_collector: RTL and testbench
=========================================

# output_event_collector

Hardware sink for monitor output streams. Samples each cycle's monitor outputs and their activation flags. Every cycle with at least one active output becomes a timestamped record in an internal FIFO. The FIFO is drained through a valid/ready port. The block replaces simulation-only `$display` logging on FPGA builds and sits directly after `topEntity`, wired to its `output_N` / `output_N_aktv` pins.

## Interface
Parameters:
- NUM_OUTPUTS, 6, number of monitor output streams
- DATA_W, 64, signed width of each output value
- TS_W, 32, cycle-timestamp width
- DEPTH, 16, FIFO records; power of two, ≥ 2

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low (rst=0 resets)
- en  in  1  global enable, shared with the monitor
- out_data  in  NUM_OUTPUTS*DATA_W  concatenated monitor outputs; output_i at bits [i*DATA_W +: DATA_W]
- out_aktv  in  NUM_OUTPUTS  activation flags; bit i = output_i_aktv
- rec_valid  out  1  head record available
- rec_ready  in  1  consumer accepts head record
- rec_ts  out  TS_W  timestamp of head record
- rec_aktv  out  NUM_OUTPUTS  activation mask of head record
- rec_data  out  NUM_OUTPUTS*DATA_W  values of head record; inactive lanes forced to 0
- count  out  $clog2(DEPTH)+1  records currently stored
- overflow  out  1  sticky: at least one record was dropped
- drop_cnt  out  16  dropped-record count, saturating at 16'hFFFF

## Operation
- Timestamp counter `ts`:
  - 0 on the first edge after reset release.
  - +1 on every edge with en=1.
  - Holds when en=0.
  - Wraps modulo 2^TS_W without any flag.
- Capture condition: edge with en=1 and out_aktv != 0.
- On capture, the record {ts, out_aktv, masked out_data} is pushed. ts is the counter value before that edge's increment.
- en=0: no capture. The read side keeps operating.
- Pop: rec_valid && rec_ready at the edge.
- Simultaneous push and pop:
  - Always legal, including when the FIFO is full.
  - The pop frees the slot used by the push.
  - count is unchanged.
- Push when full without a pop:
  - The record is discarded.
  - overflow is set.
  - drop_cnt is incremented (saturating).
  - FIFO contents are untouched.
- Push/pop on empty:
  - rec_valid=0, so the pop is ignored.
  - The push proceeds.
- overflow and drop_cnt clear only on reset.
- Reset mid-operation (rst=0 at an edge) clears the FIFO, count, overflow, drop_cnt and ts. rec_valid is 0 from the following cycle.

## Timing
- Reset values: rec_valid=0, count=0, overflow=0, drop_cnt=0, rec_ts=0, rec_aktv=0, rec_data=0.
- Capture-to-valid latency: 1 cycle. A record captured at edge k is visible with rec_valid=1 after edge k (first-word-fall-through).
- The head record is stable while rec_valid=1 and rec_ready=0.
- After a pop, the next record (if any) is presented in the following cycle. There are no bubble cycles.
- Sustained throughput: 1 push and 1 pop per cycle.
- count and overflow update at the same edge as the push/pop/drop that changes them.
- rec_ready may be asserted with rec_valid=0. This has no effect.

## Structure
- Shared package `collector_pkg`:
  - REC_W = TS_W + NUM_OUTPUTS + NUM_OUTPUTS*DATA_W
  - packed record type: ts, aktv, data fields
  - function `mask_lanes(data, aktv)` that zeroes inactive lanes
- Sub-module `record_fifo`:
  - Parameters: WIDTH and DEPTH.
  - Synchronous FWFT FIFO with pointers one bit wider than the address.
  - full/empty derived from the pointer MSB comparison.
  - Outputs: count, push-when-full-plus-pop allowed.
- Top level holds the timestamp counter, capture logic and overflow/drop accounting.

## Test plan
- Reset release, then aktv=6'b000001 with output_0=5 at ts 10 → one record: rec_ts=10, rec_aktv=000001, rec_data lane0=5, others 0; count=1.
- Active cycles at ts 3, 4, 5 with output_2 = -1, -2, -3 and rec_ready=0 → count=3. Then hold rec_ready=1 → records pop one per cycle in order with ts 3, 4, 5 and values -1, -2, -3; rec_valid falls after the third.
- DEPTH=16: fill 16 records, then 3 more active cycles with rec_ready=0 → count=16, overflow=1, drop_cnt=3. The head record is still the first one captured.
- FIFO full, active cycle with rec_ready=1 at the same edge → no drop; count stays 16; the new record is last in the drain order.
- en=0 for 5 cycles with aktv=111111 → no records and ts frozen. Next en=1 active cycle → its ts equals the pre-freeze ts + 1.
- 4 records stored and overflow=1, then rst=0 for one edge → next cycle count=0, rec_valid=0, overflow=0, drop_cnt=0. The first capture after release carries ts=0.

Source files
------------

// File: rtl/collector_pkg.sv
// Shared record layout and lane masking for the output event collector.
// Widths here match the collector's default parameters.
package collector_pkg;

   localparam int OUT_N      = 6;
   localparam int OUT_W      = 64;
   localparam int STAMP_W    = 32;
   localparam int FIFO_DEPTH = 16;
   localparam int REC_W      = STAMP_W + OUT_N + OUT_N * OUT_W;

   typedef struct packed {
      logic [STAMP_W-1:0]     ts;
      logic [OUT_N-1:0]       aktv;
      logic [OUT_N*OUT_W-1:0] data;
   } rec_t;

   function automatic logic [OUT_N*OUT_W-1:0] mask_lanes(
      input logic [OUT_N*OUT_W-1:0] data,
      input logic [OUT_N-1:0]       aktv
   );
      logic [OUT_N*OUT_W-1:0] m;
      m = '0;
      for (int i = 0; i < OUT_N; i++) begin
         if (aktv[i]) m[i*OUT_W +: OUT_W] = data[i*OUT_W +: OUT_W];
      end
      return m;
   endfunction

endpackage

// File: rtl/record_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted
// when a pop happens on the same edge.
module record_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = wr_q - rd_q;
   assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      mem_d = mem_q;
      if (do_push) begin
         mem_d[wr_q[AW-1:0]] = wdata;
         wr_d = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/output_event_collector.sv
// Timestamps cycles with active monitor outputs and queues them as
// records drained through a valid/ready port.
module output_event_collector
   import collector_pkg::*;
#(
   parameter int NUM_OUTPUTS = OUT_N,
   parameter int DATA_W      = OUT_W,
   parameter int TS_W        = STAMP_W,
   parameter int DEPTH       = FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
   input  logic [NUM_OUTPUTS-1:0]        out_aktv,
   output logic                          rec_valid,
   input  logic                          rec_ready,
   output logic [TS_W-1:0]               rec_ts,
   output logic [NUM_OUTPUTS-1:0]        rec_aktv,
   output logic [NUM_OUTPUTS*DATA_W-1:0] rec_data,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          overflow,
   output logic [15:0]                   drop_cnt
);

   localparam int LANES_W = NUM_OUTPUTS * DATA_W;
   localparam int WIDTH   = TS_W + NUM_OUTPUTS + LANES_W;

   logic [TS_W-1:0]    ts_q, ts_d;
   logic               overflow_q, overflow_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;
   logic [LANES_W-1:0] masked;
   logic [WIDTH-1:0]   wdata;
   logic [WIDTH-1:0]   rdata;
   logic               capture;
   logic               pop;
   logic               full;
   logic               empty;

   if (NUM_OUTPUTS == OUT_N && DATA_W == OUT_W) begin : g_pkg_mask
      assign masked = mask_lanes(out_data, out_aktv);
   end else begin : g_loop_mask
      always_comb begin
         masked = '0;
         for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (out_aktv[i]) masked[i*DATA_W +: DATA_W] = out_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign capture = en && (|out_aktv);
   assign pop     = rec_valid && rec_ready;
   assign wdata   = {ts_q, out_aktv, masked};

   always_comb begin
      ts_d       = ts_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (en) ts_d = ts_q + 1'b1;
      if (capture && full && !pop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ts_q       <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         ts_q       <= ts_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   record_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (capture),
      .pop   (rec_ready),
      .wdata (wdata),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign rec_valid = !empty;
   assign rec_ts    = rdata[WIDTH-1 -: TS_W];
   assign rec_aktv  = rdata[LANES_W +: NUM_OUTPUTS];
   assign rec_data  = rdata[LANES_W-1:0];
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_output_event_collector.sv
// Randomized scoreboard bench for output_event_collector.
// Stimulus updates a queue model; a monitor checks every presented record.
module tb_output_event_collector;

   localparam int N  = 6;
   localparam int W  = 64;
   localparam int TW = 32;
   localparam int D  = 16;
   localparam int LW = N * W;

   typedef struct {
      logic [TW-1:0] ts;
      logic [N-1:0]  aktv;
      logic [LW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic [LW-1:0] out_data = '0;
   logic [N-1:0]  out_aktv = '0;
   logic          rec_valid;
   logic          rec_ready = 1'b0;
   logic [TW-1:0] rec_ts;
   logic [N-1:0]  rec_aktv;
   logic [LW-1:0] rec_data;
   logic [4:0]    count;
   logic          overflow;
   logic [15:0]   drop_cnt;

   exp_t          exp_q[$];
   int            occ = 0;
   bit            ovf_m = 0;
   int            drops_m = 0;
   logic [TW-1:0] ts_m = '0;
   int            errors = 0;
   int            checks = 0;

   output_event_collector dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .out_data  (out_data),
      .out_aktv  (out_aktv),
      .rec_valid (rec_valid),
      .rec_ready (rec_ready),
      .rec_ts    (rec_ts),
      .rec_aktv  (rec_aktv),
      .rec_data  (rec_data),
      .count     (count),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   function automatic logic [LW-1:0] rand_data();
      logic [LW-1:0] d;
      for (int i = 0; i < LW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Model: a record exists only for active lanes; inactive lanes read as 0.
   function automatic logic [LW-1:0] keep_active(input logic [LW-1:0] d, input logic [N-1:0] a);
      logic [LW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) if (a[i]) r[i*W +: W] = d[i*W +: W];
      return r;
   endfunction

   task automatic step(input bit r, input bit e, input logic [N-1:0] a,
                       input logic [LW-1:0] d, input bit rdy);
      bit   pop;
      exp_t x;
      @(negedge clk);
      chk("count", count, occ);
      chk("rec_valid", rec_valid, occ > 0);
      chk("overflow", overflow, ovf_m);
      chk("drop_cnt", drop_cnt, drops_m);
      rst       = r;
      en        = e;
      out_aktv  = a;
      out_data  = d;
      rec_ready = rdy;
      if (!r) begin
         occ     = 0;
         ovf_m   = 0;
         drops_m = 0;
         ts_m    = '0;
         exp_q.delete();
      end else begin
         pop = (occ > 0) && rdy;
         if (e && a != '0) begin
            if (occ < D || pop) begin
               x.ts   = ts_m;
               x.aktv = a;
               x.data = keep_active(d, a);
               exp_q.push_back(x);
               occ++;
            end else begin
               ovf_m = 1;
               if (drops_m < 65535) drops_m++;
            end
         end
         if (pop) occ--;
         if (e) ts_m = ts_m + 1;
      end
   endtask

   initial begin : monitor
      exp_t h;
      forever begin
         @(negedge clk);
         #1;
         if (rst && rec_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_record: got ts %0h want none", rec_ts);
            end else begin
               h = exp_q[0];
               chk("rec_ts", rec_ts, h.ts);
               chk("rec_aktv", rec_aktv, h.aktv);
               chk("rec_data", rec_data, h.data);
               if (rec_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin : stim
      logic [LW-1:0]   d;
      logic signed [W-1:0] v;
      bit              r, e, rdy;
      logic [N-1:0]    a;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_rec_ts", rec_ts, 0);
      chk("reset_rec_aktv", rec_aktv, 0);
      chk("reset_rec_data", rec_data, 0);
      chk("reset_rec_valid", rec_valid, 0);

      // lone capture at ts 10 on lane 0
      repeat (10) step(1, 1, '0, '0, 0);
      d = '0;
      d[W-1:0] = 64'd5;
      step(1, 1, 6'b000001, d, 0);
      step(1, 0, '0, '0, 0);
      repeat (3) step(1, 0, '0, '0, 1);

      // negative lane-2 values at ts 3..5, then drain in order
      step(0, 0, '0, '0, 0);
      repeat (3) step(1, 1, '0, '0, 0);
      for (int k = 1; k <= 3; k++) begin
         d = '0;
         v = -k;
         d[2*W +: W] = v;
         step(1, 1, 6'b000100, d, 0);
      end
      step(1, 0, '0, '0, 0);
      repeat (4) step(1, 0, '0, '0, 1);

      // fill, overflow by 3, then full with simultaneous pop
      for (int k = 0; k < D + 3; k++) step(1, 1, 6'(k % 63 + 1), rand_data(), 0);
      repeat (3) step(1, 1, 6'($urandom_range(1, 63)), rand_data(), 1);
      repeat (D + 2) step(1, 0, '0, '0, 1);

      // frozen timestamp while disabled
      repeat (5) step(1, 0, 6'b111111, rand_data(), 0);
      step(1, 1, 6'b111111, rand_data(), 0);

      // reset with records stored and overflow set
      repeat (3) step(1, 1, 6'($urandom_range(1, 63)), rand_data(), 0);
      step(1, 0, '0, '0, 0);
      step(0, 0, '0, '0, 0);
      step(1, 1, 6'b010010, rand_data(), 1);

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         r   = ($urandom_range(0, 499) != 0);
         e   = ($urandom_range(0, 99) < 85);
         a   = ($urandom_range(0, 9) < 3) ? '0 : 6'($urandom);
         rdy = $urandom_range(0, 1) == 1;
         step(r, e, a, rand_data(), rdy);
      end

      repeat (D + 4) step(1, 0, '0, '0, 1);
      @(negedge clk);
      #2;
      chk("drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
